// File: rtl/in_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// in_port_arbiter_if
// Bundles the requester handshake and the processor-facing inR3 port of the
// input-port arbiter into one connection.
//
// Parameters:
//   N_REQ      - number of requesters
//   DATA_WIDTH - byte width of each requester and of inR3
//
// Signals:
//   req_valid  - per-requester byte-offered flag           (requesters -> arbiter)
//   req_data   - packed bytes, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  - one-hot grant/accept                      (arbiter -> requesters)
//   rd_strobe  - one-cycle pulse, processor consumed inR3  (processor -> arbiter)
//   inR3       - captured byte                             (arbiter -> processor)
//   inR3_valid - inR3 holds an unconsumed byte
//   grant_id   - index of requester whose byte is on inR3
//   dropped    - one-cycle pulse when an unread byte is dropped on timeout
//
// Modports:
//   slave  - arbiter side
//   master - environment side (requesters + processor)
// -----------------------------------------------------------------------------
interface in_port_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            req_ready;
    logic                        rd_strobe;
    logic [DATA_WIDTH-1:0]       inR3;
    logic                        inR3_valid;
    logic [ID_W-1:0]             grant_id;
    logic                        dropped;

    modport slave (
        input  req_valid,
        input  req_data,
        input  rd_strobe,
        output req_ready,
        output inR3,
        output inR3_valid,
        output grant_id,
        output dropped
    );

    modport master (
        output req_valid,
        output req_data,
        output rd_strobe,
        input  req_ready,
        input  inR3,
        input  inR3_valid,
        input  grant_id,
        input  dropped
    );
endinterface

// File: rtl/in_port_arbiter.sv
// -----------------------------------------------------------------------------
// in_port_arbiter
// Round-robin arbiter sharing the processor's single 8-bit input port (inR3)
// among N_REQ requesters. In IDLE one winner is granted combinationally; its
// byte is captured on the following edge and held on inR3 until the processor
// pulses rd_strobe, after which the arbiter returns to IDLE and re-arbitrates.
//
// Parameters:
//   N_REQ       - number of requesters (2..8)
//   DATA_WIDTH  - byte width
//   TIMEOUT_CYC - HOLD cycles before an unread byte is dropped
//
// Ports:
//   clk   - system clock, rising edge
//   Reset - asynchronous, active-high reset
//   bus   - in_port_arbiter_if.slave (requester handshake + inR3 port)
//
// Optional feature macro: IN_ARB_TIMEOUT_EN
//   Defined     : an unread byte is dropped after TIMEOUT_CYC HOLD cycles,
//                 with a one-cycle 'dropped' pulse.
//   Not defined : HOLD persists until rd_strobe, 'dropped' is tied low.
// -----------------------------------------------------------------------------
module in_port_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic               clk,
    input  logic               Reset,
    in_port_arbiter_if.slave   bus
);

    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [ID_W-1:0]       r_ptr;
    logic [ID_W-1:0]       r_grant_id;
    logic [DATA_WIDTH-1:0] r_inR3;
    logic                  r_inR3_valid;

    logic [ID_W:0]         w_sum;
    logic [ID_W:0]         w_cand;
    logic                  w_hit;
    logic                  w_found;
    logic [ID_W-1:0]       w_winner;
    logic [ID_W-1:0]       w_ptr_nxt;
    logic [DATA_WIDTH-1:0] w_win_data;
    logic [N_REQ-1:0]      w_req_ready;
    logic                  w_take;
    logic                  w_read;
    logic                  w_drop;

    // Round-robin search: first valid requester starting at r_ptr, wrapping mod N_REQ.
    always_comb begin
        w_sum    = '0;
        w_cand   = '0;
        w_hit    = 1'b0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum    = {1'b0, r_ptr} + (ID_W+1)'(k);
            // Sum never exceeds 2*N_REQ-2, so one subtraction is enough to wrap.
            w_cand   = (w_sum >= (ID_W+1)'(N_REQ)) ? (w_sum - (ID_W+1)'(N_REQ)) : w_sum;
            w_hit    = !w_found && bus.req_valid[w_cand[ID_W-1:0]];
            w_winner = w_hit ? w_cand[ID_W-1:0] : w_winner;
            w_found  = w_found | w_hit;
        end
    end

    // Byte mux selecting the winner's lane of the packed request data.
    always_comb begin
        w_win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_win_data = (w_winner == ID_W'(i)) ? bus.req_data[i*DATA_WIDTH +: DATA_WIDTH]
                                                : w_win_data;
        end
    end

    // Pointer moves to the requester just after the winner.
    always_comb begin
        w_ptr_nxt = (w_winner == ID_W'(N_REQ-1)) ? '0 : (w_winner + ID_W'(1));
    end

`ifdef IN_ARB_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_dropped;
`else
    // Timeout depth has no effect when the timeout feature is not built in.
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYC > 0);
`endif

    // Next-state and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = '0;
        w_take      = 1'b0;
        w_read      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // rd_strobe is deliberately ignored here.
                if (w_found) begin
                    w_req_ready = {{(N_REQ-1){1'b0}}, 1'b1} << w_winner;
                    w_take      = 1'b1;
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // A read in the final timeout cycle takes precedence over the drop.
                if (bus.rd_strobe) begin
                    w_read      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
`ifdef IN_ARB_TIMEOUT_EN
                else if (r_tmo_cnt == TMO_W'(TIMEOUT_CYC-1)) begin
                    w_drop      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
`endif
                else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and the registered inR3 datapath.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_grant_id   <= '0;
            r_inR3       <= '0;
            r_inR3_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_inR3       <= w_win_data;
                r_grant_id   <= w_winner;
                r_inR3_valid <= 1'b1;
                r_ptr        <= w_ptr_nxt;
            end else if (w_read || w_drop) begin
                // inR3 and grant_id keep the last captured byte and its source.
                r_inR3_valid <= 1'b0;
            end else begin
                r_inR3_valid <= r_inR3_valid;
            end
        end
    end

`ifdef IN_ARB_TIMEOUT_EN
    // HOLD-cycle counter and the one-cycle drop pulse.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_tmo_cnt <= '0;
            r_dropped <= 1'b0;
        end else begin
            r_dropped <= w_drop;
            if (w_take) begin
                r_tmo_cnt <= '0;
            end else if ((r_state == ST_HOLD) && !bus.rd_strobe && !w_drop) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end else begin
                r_tmo_cnt <= r_tmo_cnt;
            end
        end
    end

    assign bus.dropped = r_dropped;
`else
    assign bus.dropped = 1'b0;
`endif

    assign bus.req_ready  = w_req_ready;
    assign bus.inR3       = r_inR3;
    assign bus.inR3_valid = r_inR3_valid;
    assign bus.grant_id   = r_grant_id;

endmodule

// File: doc/in_port_arbiter.md
# in_port_arbiter

Round-robin arbiter that shares the processor's single 8-bit external input port (`inR3`) among several external requesters. Each requester offers a byte with a valid/ready handshake; the arbiter captures one winner's byte, presents it stably on `inR3` until the processor signals it has consumed it, then re-arbitrates. It sits between peripheral sources and the `inR3` input of `top`.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `DATA_WIDTH`, 8, byte width of each requester and of `inR3`
- `TIMEOUT_CYC`, 16, HOLD cycles before an unread byte is dropped (only with `IN_ARB_TIMEOUT_EN`)
- `clk`  input  1  system clock, all state updates on rising edge
- `Reset`  input  1  asynchronous, active-high reset
- `req_valid`  input  N_REQ  per-requester byte-offered flag
- `req_data`  input  N_REQ*DATA_WIDTH  packed bytes, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- `req_ready`  output  N_REQ  one-hot grant/accept, combinational in IDLE
- `rd_strobe`  input  1  one-cycle pulse: processor has consumed `inR3`
- `inR3`  output  DATA_WIDTH  captured byte, registered
- `inR3_valid`  output  1  `inR3` holds an unconsumed byte
- `grant_id`  output  $clog2(N_REQ)  index of requester whose byte is on `inR3`
- `dropped`  output  1  one-cycle pulse on timeout drop (tied 0 without `IN_ARB_TIMEOUT_EN`)

## Operation
- Two states: IDLE, HOLD. Reset → IDLE.
- Reset values: `inR3`=0, `inR3_valid`=0, `grant_id`=0, `dropped`=0, `req_ready`=0, round-robin pointer `ptr`=0, timeout counter=0.
- IDLE: winner w = first i with `req_valid[i]`=1, searching ptr, ptr+1, … wrapping mod N_REQ. `req_ready[w]`=1 combinationally; all others 0. No valid → all ready 0, stay IDLE.
- Transfer occurs at edge where `req_valid[w]` && `req_ready[w]`: `inR3`←byte w, `grant_id`←w, `inR3_valid`←1, `ptr`←(w+1) mod N_REQ, counter←0, state→HOLD.
- HOLD: `req_ready`=0. `inR3` and `grant_id` frozen. On `rd_strobe`: `inR3_valid`←0, state→IDLE.
- `rd_strobe` in IDLE: ignored, no state change.
- `inR3` keeps last captured byte after read; only a new transfer changes it.
- Requesters hold `req_valid` and data stable until they see `req_ready`; a requester dropping valid before grant is simply skipped.
- Reset asserted mid-HOLD: immediate return to reset values; pending byte discarded, no `dropped` pulse.

## Timing
- `req_valid` rising in IDLE → `req_ready` same cycle → `inR3_valid`=1 and `inR3` updated the following cycle (latency 1).
- `rd_strobe` at edge k → `inR3_valid`=0 after edge k; earliest next grant in cycle k+1 (IDLE), its byte visible after edge k+1.
- Sustained throughput: one byte per 2 cycles max.
- Fairness: with all N_REQ requesting continuously, grant order cycles 0,1,…,N_REQ-1,0; no requester waits more than N_REQ transfers.

## Configuration
- `IN_ARB_TIMEOUT_EN` defined: counter increments each HOLD cycle without `rd_strobe`; when it reaches TIMEOUT_CYC-1 and no `rd_strobe` that cycle, next edge: `inR3_valid`←0, `dropped`=1 for one cycle, state→IDLE, `ptr` unchanged (already advanced). `rd_strobe` on the same cycle wins: normal read, no `dropped`.
- Not defined: no counter, `dropped` tied 0, HOLD persists indefinitely until `rd_strobe`.

## Test plan
- Reset: assert `Reset` asynchronously mid-cycle → all outputs 0 immediately, state IDLE; release, no requests → outputs stay 0.
- Single request: `req_valid[2]`=1, data 0x55 → `req_ready[2]`=1 same cycle; next cycle `inR3`=0x55, `inR3_valid`=1, `grant_id`=2; `rd_strobe` pulse → `inR3_valid`=0, `inR3` stays 0x55.
- Round robin: all four valid, bytes 0xF0,0x0F,0xFF,0x01, `rd_strobe` one cycle after each `inR3_valid` → grants 0,1,2,3,0 in order, byte sequence matches, one transfer per 2 cycles.
- Pointer wrap: after grant to 3, only requesters 0 and 3 valid → next grant 0, then 3.
- Stray/overlap: `rd_strobe` in IDLE → no change; requester 1 deasserts valid before grant while 2 valid → grant 2.
- Timeout (`IN_ARB_TIMEOUT_EN`, TIMEOUT_CYC=16): capture 0xAA, no `rd_strobe` → `dropped` pulses after 16th HOLD cycle, `inR3_valid`=0; repeat with `rd_strobe` on the 16th cycle → no `dropped`.
